// File: rtl/datausb1_rx.sv
// datausb1_rx: 8N1 UART receiver with 3-sample majority vote, valid/ack holding register, framing-error and overrun flags
module datausb1_rx #(
  parameter int CLKS_PER_BIT = 521
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       overrun
);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic s1, rxs, rxs_q;
  logic [CW-1:0] cnt;
  logic [2:0] bitn;
  logic [7:0] sh;
  logic [1:0] smp;
  logic fall, dec, vote, good, bad;
  assign fall = (state == IDLE) && !rxs && rxs_q;
  // cnt is the offset within the current bit; the centre sits at HALF, the vote completes one cycle later
  assign dec = (state != IDLE) && (cnt == CW'(HALF + 1));
  assign vote = (smp[0] & smp[1]) | (smp[0] & rxs) | (smp[1] & rxs);
  assign good = dec && (state == STOP) && vote;
  assign bad = dec && (state == STOP) && !vote;
  assign rx_busy = state != IDLE;
  always_comb begin
    state_n = state;
    if (fall)
      state_n = START;
    else if (dec)
      state_n = (state == START) ? (vote ? IDLE : DATA) :
                (state == DATA)  ? ((bitn == 3'd7) ? STOP : DATA) : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst)
      state <= IDLE;
    else
      state <= state_n;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= 1'b1;
      rxs <= 1'b1;
      rxs_q <= 1'b1;
      cnt <= '0;
      bitn <= '0;
      sh <= '0;
      smp <= '0;
      rx_data <= '0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else begin
      s1 <= rx;
      rxs <= s1;
      rxs_q <= rxs;
      cnt <= fall ? CW'(1) : (state == IDLE) ? '0 :
             (cnt == CW'(CLKS_PER_BIT - 1)) ? '0 : cnt + CW'(1);
      if (cnt == CW'(HALF - 1))
        smp[0] <= rxs;
      if (cnt == CW'(HALF))
        smp[1] <= rxs;
      if (fall)
        bitn <= '0;
      else if (dec && state == DATA) begin
        sh <= {vote, sh[7:1]};
        bitn <= bitn + 3'd1;
      end
      frame_err <= bad;
      overrun <= good && rx_valid && !rx_ack;
      if (good) begin
        rx_data <= sh;
        rx_valid <= 1'b1;
      end else if (rx_ack)
        rx_valid <= 1'b0;
    end
endmodule

// File: doc/datausb1_rx.md
Name: datausb1_rx

Overview:
- RS-232 UART receiver; the receive end of the 8N1 serial link driven by the team's transmitter.
- Frame: start bit (0), 8 data bits LSB first, one stop bit (1). Idle line is high.
- Synchronises the asynchronous rx pin and takes a 3-sample majority vote at each bit centre.
- Presents each received byte on a valid/ack holding register, with framing-error and overrun flags.

Parameters:
- CLKS_PER_BIT, 521, clk cycles per bit (9600 baud at the system clock); legal minimum 4.
- HALF, CLKS_PER_BIT/2 (integer division), local; offset from the start edge to the bit-0 centre.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous active-high reset
- rx  input  1  RS-232 receive pin, asynchronous to clk
- rx_data  output  8  last received byte, stable while rx_valid=1
- rx_valid  output  1  byte available; held until acknowledged
- rx_ack  input  1  consumer accept; effective only when rx_valid=1
- rx_busy  output  1  high whenever state is not IDLE
- frame_err  output  1  one-cycle pulse: stop bit sampled 0
- overrun  output  1  one-cycle pulse: new byte completed while rx_valid=1 and no rx_ack

Behaviour:
- Reset values (async assert, sync release):
  - rx_data=0, rx_valid=0, rx_busy=0, frame_err=0, overrun=0.
  - State=IDLE; bit counter and cycle counter = 0.
  - Both synchroniser flops and the edge-detect history register = 1, so no false edge after reset.
- Synchroniser: 2 flops; rxs is the second flop. Pin-to-rxs latency is 2 cycles.
- Cycle counter: width $clog2(CLKS_PER_BIT)+1. t0 = cycle in which rxs=0 and previous rxs=1.
- Bit centres: bit k (k=0 start, 1..8 data, 9 stop) has centre c_k = t0 + HALF + k*CLKS_PER_BIT.
- Sampling: rxs is sampled at c_k-1, c_k and c_k+1. Bit value = majority of the 3 samples; decided at c_k+1.
- States:
  - IDLE: wait for the falling edge; go to START at t0.
  - START: at the start decision:
    - value 1 -> false start; back to IDLE, no flags.
    - value 0 -> DATA.
  - DATA: each decided bit shifts into bit 7 of the shift register (right shift), so LSB ends in bit 0. After the 8th data bit -> STOP.
  - STOP: at the stop decision, return to IDLE in the same transition so a back-to-back start edge is caught.
    - value 1 -> load rx_data and set rx_valid, visible at c_9+2.
    - value 0 -> frame_err pulse at c_9+2; byte discarded; rx_data and rx_valid unchanged.
- Edge detection in IDLE requires rxs history=1. If the line is stuck low after a framing error, no new frame starts until rxs returns high and falls again.
- Handshake:
  - rx_ack=1 with rx_valid=1 clears rx_valid next cycle.
  - rx_ack while rx_valid=0 is ignored.
- Overrun: a good byte completes while rx_valid=1 and rx_ack=0:
  - rx_data is overwritten with the new byte; rx_valid stays 1; overrun pulses 1 cycle.
- Same cycle as rx_ack: a good byte completing in the same cycle as an effective rx_ack loads the new byte, rx_valid stays 1, no overrun.
- Reset mid-frame: partial byte lost; no flags after release; the receiver resumes in IDLE.

Test Plan (CLKS_PER_BIT=16, HALF=8):
- Send 0xA5 as 8N1, rx_ack held 0:
  - rx_valid=1 at c_9+2; rx_data=8'hA5; frame_err=0; rx_busy low in the same cycle.
  - Then assert rx_ack for 1 cycle -> rx_valid=0 next cycle.
- Glitch: rx low for 3 cycles, then high -> returns to IDLE after the start decision; rx_valid, frame_err and overrun stay 0. A following valid frame of 0x3C is received correctly.
- Send 0x55 with the stop bit forced 0 -> frame_err pulses exactly 1 cycle; rx_valid stays 0; rx_data keeps its previous value.
- Send 0x11 then 0x22 back-to-back with no rx_ack:
  - overrun pulses once at the second completion.
  - rx_data=8'h22; rx_valid=1.
- Send 0xFF with a 1-cycle 0 glitch at the centre sample of every data bit -> majority vote yields rx_data=8'hFF.
- Assert rst during data bit 4 of 0x81, then release -> all outputs 0, no flags. The next full frame 0x81 is received as 8'h81.
